// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response channels of the ALU issue controller.
// ALU_TRAP_EN adds the out_err response flag.
interface alu_issue_ctrl_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_aluop;
  logic [5:0]   in_funct;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [2:0]   alu_f;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_y;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;
  logic         out_cout;
  logic         out_zero;
`ifdef ALU_TRAP_EN
  logic         out_err;
`endif

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b, alu_y, alu_cout, out_ready,
    output in_ready, alu_f, alu_a, alu_b, out_valid, out_y, out_cout, out_zero
`ifdef ALU_TRAP_EN
    , output out_err
`endif
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b, alu_y, alu_cout, out_ready,
    input  in_ready, alu_f, alu_a, alu_b, out_valid, out_y, out_cout, out_zero
`ifdef ALU_TRAP_EN
    , input out_err
`endif
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential issue/capture front end for the 8-bit combinational ALU.
// Optional ALU_TRAP_EN: illegal funct codes return an error response instead of ADD.
module alu_issue_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [2:0]       alu_f_r;
  logic [N-1:0]     alu_a_r, alu_b_r;
  logic [N-1:0]     out_y_r;
  logic             out_cout_r, out_zero_r, out_valid_r, err_r;
  logic [CNT_W-1:0] ops_done_r;
  logic             in_ready_s, accept_s, trap_s;
  logic [2:0]       dec_f_s;

  // Unknown funct codes fall back to ADD; the trap build screens them separately.
  function automatic logic [2:0] decode_f(input logic [1:0] aluop, input logic [5:0] funct);
    logic [2:0] f;
    case (aluop)
      2'b00:   f = 3'b010;
      2'b01:   f = 3'b110;
      default: begin
        case (funct)
          6'b100000: f = 3'b010;
          6'b100010: f = 3'b110;
          6'b100100: f = 3'b000;
          6'b100101: f = 3'b001;
          6'b101010: f = 3'b111;
          default:   f = 3'b010;
        endcase
      end
    endcase
    return f;
  endfunction

`ifdef ALU_TRAP_EN
  function automatic logic funct_illegal(input logic [1:0] aluop, input logic [5:0] funct);
    logic bad;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: bad = 1'b0;
      default:                                               bad = 1'b1;
    endcase
    return aluop[1] & bad;
  endfunction

  assign trap_s      = accept_s & funct_illegal(bus.in_aluop, bus.in_funct);
  assign bus.out_err = err_r;
`else
  assign trap_s      = 1'b0;
`endif

  // In DONE a new request is taken only on the edge that also retires the response.
  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign dec_f_s    = decode_f(bus.in_aluop, bus.in_funct);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = trap_s ? DONE : EXEC;
        else          state_s = IDLE;
      end
      EXEC: state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (accept_s) state_s = trap_s ? DONE : EXEC;
          else          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, ALU operand, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alu_f_r     <= 3'b000;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      out_y_r     <= '0;
      out_cout_r  <= 1'b0;
      out_zero_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      ops_done_r  <= '0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
      if (accept_s && !trap_s) begin
        alu_f_r <= dec_f_s;
        alu_a_r <= bus.in_a;
        alu_b_r <= bus.in_b;
      end
      if (state_r == EXEC) begin
        out_y_r    <= bus.alu_y;
        out_cout_r <= (alu_f_r[1:0] == 2'b10) & bus.alu_cout;
        out_zero_r <= (bus.alu_y == '0);
        err_r      <= 1'b0;
      end else if (trap_s) begin
        out_y_r    <= '0;
        out_cout_r <= 1'b0;
        out_zero_r <= 1'b0;
        err_r      <= 1'b1;
      end
      // Error responses are not counted as completed operations.
      if ((state_r == DONE) && bus.out_ready && !err_r && (ops_done_r != CNT_MAX)) begin
        ops_done_r <= ops_done_r + CNT_ONE;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.alu_f     = alu_f_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.out_zero  = out_zero_r;
  assign ops_done      = ops_done_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] ops_done;
  int               errors;
  int               checks;
  int               exp_ops;

  alu_issue_ctrl_if #(.N(N)) bus ();

  alu_issue_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ops_done (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: S = A + (F2 ? ~B : B) + F2, result selected by F[1:0].
  logic [N-1:0] bb_m;
  logic [N:0]   sum_m;
  always_comb begin
    bb_m  = bus.alu_f[2] ? ~bus.alu_b : bus.alu_b;
    sum_m = {1'b0, bus.alu_a} + {1'b0, bb_m} + {{N{1'b0}}, bus.alu_f[2]};
    case (bus.alu_f[1:0])
      2'b00:   bus.alu_y = bus.alu_a & bb_m;
      2'b01:   bus.alu_y = bus.alu_a | bb_m;
      2'b10:   bus.alu_y = sum_m[N-1:0];
      default: bus.alu_y = {{(N-1){1'b0}}, sum_m[N-1]};
    endcase
    bus.alu_cout = sum_m[N];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_ops();
    if (exp_ops < 3) exp_ops = exp_ops + 1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_aluop = 2'b00;
    bus.in_funct = 6'b000000;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
    bus.out_ready = 1'b0;
    exp_ops      = 0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", bus.out_y); end
    checks++; if ({bus.alu_f, bus.alu_a, bus.alu_b} !== 19'h0) begin errors++; $display("FAIL reset_alu: got %h %h %h expected 0", bus.alu_f, bus.alu_a, bus.alu_b); end
    checks++; if ({bus.out_cout, bus.out_zero, ops_done} !== 4'h0) begin errors++; $display("FAIL reset_misc: got %b%b %h expected 0", bus.out_cout, bus.out_zero, ops_done); end
`ifdef ALU_TRAP_EN
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.out_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [7:0] y;
    logic       c;
    logic       z;
  } vec_t;

  task automatic test_decode();
    vec_t v [7];
    v[0] = '{2'b10, 6'b100000, 8'h02, 8'h03, 3'b010, 8'h05, 1'b0, 1'b0};
    v[1] = '{2'b10, 6'b100010, 8'h02, 8'h03, 3'b110, 8'hFF, 1'b0, 1'b0};
    v[2] = '{2'b10, 6'b101010, 8'h02, 8'h03, 3'b111, 8'h01, 1'b0, 1'b0};
    v[3] = '{2'b01, 6'b000000, 8'h03, 8'h03, 3'b110, 8'h00, 1'b1, 1'b1};
    v[4] = '{2'b10, 6'b100100, 8'h0F, 8'hF0, 3'b000, 8'h00, 1'b0, 1'b1};
    v[5] = '{2'b10, 6'b100101, 8'hFF, 8'h01, 3'b001, 8'hFF, 1'b0, 1'b0};
    v[6] = '{2'b00, 6'b111111, 8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_aluop = v[i].op;
      bus.in_funct = v[i].fn;
      bus.in_a     = v[i].a;
      bus.in_b     = v[i].b;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.alu_f !== v[i].f) begin errors++; $display("FAIL dec%0d_f: got %b expected %b", i, bus.alu_f, v[i].f); end
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL dec%0d_exec: got valid=%b ready=%b expected 0 0", i, bus.out_valid, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if ({bus.out_y, bus.out_cout, bus.out_zero} !== {v[i].y, v[i].c, v[i].z}) begin errors++; $display("FAIL dec%0d_resp: got y=%h c=%b z=%b expected y=%h c=%b z=%b", i, bus.out_y, bus.out_cout, bus.out_zero, v[i].y, v[i].c, v[i].z); end
`ifdef ALU_TRAP_EN
      checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL dec%0d_err: got %b expected 0", i, bus.out_err); end
`endif
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bump_ops();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dec%0d_retire: got %b expected 0", i, bus.out_valid); end
      checks++; if (ops_done !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL dec%0d_ops: got %0d expected %0d", i, ops_done, exp_ops); end
    end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.in_aluop = 2'b00; bus.in_a = 8'h0A; bus.in_b = 8'h14;
    tick();
    bus.in_aluop = 2'b01; bus.in_a = 8'h07; bus.in_b = 8'h01;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_hs: got valid=%b ready=%b expected 1 0", i, bus.out_valid, bus.in_ready); end
      checks++; if ({bus.out_y, bus.alu_a, bus.alu_b, bus.alu_f} !== {8'h1E, 8'h0A, 8'h14, 3'b010}) begin errors++; $display("FAIL bp%0d_hold: got y=%h a=%h b=%h f=%b expected 1e 0a 14 010", i, bus.out_y, bus.alu_a, bus.alu_b, bus.alu_f); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bump_ops();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", bus.out_valid); end
    checks++; if ({bus.alu_f, bus.alu_a, bus.alu_b} !== {3'b110, 8'h07, 8'h01}) begin errors++; $display("FAIL b2b_alu: got %b %h %h expected 110 07 01", bus.alu_f, bus.alu_a, bus.alu_b); end
    checks++; if (ops_done !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL b2b_ops: got %0d expected %0d", ops_done, exp_ops); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h06) begin errors++; $display("FAIL b2b_resp: got valid=%b y=%h expected 1 06", bus.out_valid, bus.out_y); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bump_ops();
    checks++; if (ops_done !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL sat_ops: got %0d expected %0d", ops_done, exp_ops); end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_aluop = 2'b00; bus.in_a = 8'h11; bus.in_b = 8'h22;
    tick();
    bus.in_valid = 1'b0;
    rst_n   = 1'b0;
    exp_ops = 0;
    #1;
    checks++; if ({bus.out_valid, bus.out_y, ops_done} !== 11'h0) begin errors++; $display("FAIL rstmid_out: got valid=%b y=%h ops=%0d expected 0", bus.out_valid, bus.out_y, ops_done); end
    checks++; if ({bus.alu_f, bus.alu_a} !== 11'h0) begin errors++; $display("FAIL rstmid_alu: got %b %h expected 0", bus.alu_f, bus.alu_a); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got ready=%b valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    bus.in_valid = 1'b1; bus.in_aluop = 2'b10; bus.in_funct = 6'b000000;
    bus.in_a = 8'h02; bus.in_b = 8'h03;
    tick();
    bus.in_valid = 1'b0;
`ifdef ALU_TRAP_EN
    checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) begin errors++; $display("FAIL trap_resp: got valid=%b err=%b expected 1 1", bus.out_valid, bus.out_err); end
    checks++; if ({bus.out_y, bus.out_cout, bus.out_zero} !== 10'h0) begin errors++; $display("FAIL trap_data: got y=%h c=%b z=%b expected 0", bus.out_y, bus.out_cout, bus.out_zero); end
    checks++; if ({bus.alu_f, bus.alu_a, bus.alu_b} !== 19'h0) begin errors++; $display("FAIL trap_alu: got %b %h %h expected 0", bus.alu_f, bus.alu_a, bus.alu_b); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
`else
    checks++; if (bus.alu_f !== 3'b010 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ill_f: got f=%b valid=%b expected 010 0", bus.alu_f, bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h05) begin errors++; $display("FAIL ill_resp: got valid=%b y=%h expected 1 05", bus.out_valid, bus.out_y); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bump_ops();
`endif
    checks++; if (ops_done !== exp_ops[CNT_W-1:0] || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ill_ops: got ops=%0d valid=%b expected %0d 0", ops_done, bus.out_valid, exp_ops); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
